// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port I/D cache memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    // Requester IDs, also used as bit positions in the one-hot grant.
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY_I  = 2'd1;
    localparam logic [1:0] S_BUSY_D  = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = S_IDLE,
        BUSY_I  = S_BUSY_I,
        BUSY_D  = S_BUSY_D,
        RELEASE = S_RELEASE
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin picker: under contention the requester
// that was not served last wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       i_req_i,
    input  logic       i_req_d,
    input  logic       i_last_gnt,
    output logic [1:0] o_gnt
);

    // One-hot grant, indexed by requester ID.
    always_comb begin
        o_gnt = '0;
        if (i_req_i && i_req_d) begin
            if (i_last_gnt == REQ_I) o_gnt[REQ_D] = 1'b1;
            else                     o_gnt[REQ_I] = 1'b1;
        end else if (i_req_i) begin
            o_gnt[REQ_I] = 1'b1;
        end else if (i_req_d) begin
            o_gnt[REQ_D] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one off-chip memory slave between the I-cache and D-cache line
// ports. One full-line transaction at a time, round-robin under contention,
// with a RELEASE cycle so the served cache can drop its request.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_gnt;
    logic [1:0]        w_gnt;
    logic              w_d_req;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_done_i;
    logic              w_done_d;

    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_i_ready;
    logic              r_d_ready;

    assign w_d_req = d_read | d_write;

    rr_arb2 u_rr (
        .i_req_i    (i_read),
        .i_req_d    (w_d_req),
        .i_last_gnt (r_last_gnt),
        .o_gnt      (w_gnt)
    );

    // Next state plus grant/completion strobes; grants only taken in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_done_i    = 1'b0;
        w_done_d    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt[REQ_I]) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = BUSY_I;
                end else if (w_gnt[REQ_D]) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = BUSY_D;
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    w_done_i    = 1'b1;
                    w_state_nxt = RELEASE;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    w_done_d    = 1'b1;
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Bus latches, strobes, returned data and ready pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_i_ready   <= 1'b0;
            r_d_ready   <= 1'b0;
            r_last_gnt  <= REQ_I;
        end else begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;
            if (w_grant_i) begin
                r_mem_addr  <= i_addr;
                r_mem_read  <= 1'b1;
                r_mem_write <= 1'b0;
            end
            // Read+write together is treated as a write-back.
            if (w_grant_d) begin
                r_mem_addr  <= d_addr;
                r_mem_wdata <= d_wdata;
                r_mem_read  <= ~d_write;
                r_mem_write <= d_write;
            end
            if (w_done_i) begin
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
                r_i_rdata   <= mem_rdata;
                r_i_ready   <= 1'b1;
                r_last_gnt  <= REQ_I;
            end
            if (w_done_d) begin
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
                r_d_rdata   <= mem_rdata;
                r_d_ready   <= 1'b1;
                r_last_gnt  <= REQ_D;
            end
        end
    end

    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_rdata   = r_i_rdata;
    assign i_ready   = r_i_ready;
    assign d_rdata   = r_d_rdata;
    assign d_ready   = r_d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a scoreboard of expected bus
// transactions and a small memory responder driven from the sequence.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_read;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            is_d;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   rdy_cyc = 0;
    int   last_wait = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_d, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        exp_t e;
        e.is_d = is_d; e.wr = wr; e.addr = a; e.wdata = wd;
        sb.push_back(e);
    endtask

    // Wait for the next bus transaction, check it against the scoreboard,
    // complete it after lat cycles with data rd and check the ready pulse.
    task automatic serve_one(input int lat, input logic [DW-1:0] rd, input bit chg, input bit chk_gap);
        exp_t e;
        int   w;
        w = 0;
        while (!(mem_read || mem_write) && w < 50) begin
            tick();
            w++;
        end
        chk("bus_start", {127'd0, mem_read | mem_write}, 1);
        if (!(mem_read || mem_write)) return;
        last_wait = w;
        chk("sb_nonempty", {127'd0, sb.size() > 0}, 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        if (chk_gap) chk("dead_cycles", cyc - rdy_cyc, 2);
        chk("mem_read", {127'd0, mem_read}, {127'd0, !e.wr});
        chk("mem_write", {127'd0, mem_write}, {127'd0, e.wr});
        chk("mem_addr", mem_addr, e.addr);
        if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
        for (int k = 1; k < lat; k++) begin
            tick();
            if (chg && k == 1) i_addr = 28'hABCDEF0;
            chk("addr_hold", mem_addr, e.addr);
            chk("no_early_ready", {126'd0, i_ready, d_ready}, 0);
        end
        mem_ready = 1'b1;
        mem_rdata = rd;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        rdy_cyc = cyc;
        chk("i_ready", {127'd0, i_ready}, {127'd0, !e.is_d});
        chk("d_ready", {127'd0, d_ready}, {127'd0, e.is_d});
        chk("strobes_off", {126'd0, mem_read, mem_write}, 0);
        if (!e.wr) begin
            if (e.is_d) chk("d_rdata", d_rdata, rd);
            else        chk("i_rdata", i_rdata, rd);
        end
        tick();
        chk("ready_one_cycle", {126'd0, i_ready, d_ready}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        repeat (3) tick();
        chk("rst_strobes", {126'd0, mem_read, mem_write}, 0);
        chk("rst_ready", {126'd0, i_ready, d_ready}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);

        // Contention straight out of reset: D first, then I.
        rst_n = 1'b1;
        i_read = 1'b1; i_addr = 28'h100;
        d_read = 1'b1; d_addr = 28'h200;
        push(1, 0, 28'h200, '0);
        push(0, 0, 28'h100, '0);
        serve_one(3, {4{32'hA5A5_0001}}, 0, 0);
        chk("first_grant_latency", last_wait, 1);
        d_read = 1'b0;
        serve_one(3, {4{32'h5A5A_0002}}, 0, 1);
        i_read = 1'b0;

        // Single write-back.
        tick();
        d_write = 1'b1; d_addr = 28'h20; d_wdata = 128'hDEADBEEF_00000000_00000000_00000001;
        push(1, 1, 28'h20, 128'hDEADBEEF_00000000_00000000_00000001);
        serve_one(4, {4{32'h0BAD_F00D}}, 0, 0);
        d_write = 1'b0;

        // Single fetch, address changed while granted.
        tick();
        i_read = 1'b1; i_addr = 28'h0000010;
        push(0, 0, 28'h10, '0);
        serve_one(5, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1, 0);
        chk("i_grant_latency", last_wait, 1);
        i_read = 1'b0;

        // Both held: D, I, D, I.
        tick();
        i_read = 1'b1; i_addr = 28'h300;
        d_read = 1'b1; d_addr = 28'h400;
        push(1, 0, 28'h400, '0);
        push(0, 0, 28'h300, '0);
        push(1, 0, 28'h400, '0);
        push(0, 0, 28'h300, '0);
        serve_one(2, {4{32'h1111_0001}}, 0, 0);
        serve_one(2, {4{32'h2222_0002}}, 0, 1);
        serve_one(2, {4{32'h3333_0003}}, 0, 1);
        serve_one(2, {4{32'h4444_0004}}, 0, 1);
        i_read = 1'b0; d_read = 1'b0;

        // Read and write together is serviced as a write.
        tick();
        d_read = 1'b1; d_write = 1'b1; d_addr = 28'h55; d_wdata = {4{32'hCAFE_BABE}};
        push(1, 1, 28'h55, {4{32'hCAFE_BABE}});
        serve_one(2, '0, 0, 0);
        d_read = 1'b0; d_write = 1'b0;
        chk("sb_drained", sb.size(), 0);

        // Reset during BUSY_D abandons the transaction.
        tick();
        d_read = 1'b1; d_addr = 28'h777;
        begin
            int w;
            w = 0;
            while (!mem_read && w < 50) begin tick(); w++; end
        end
        chk("rstmid_busy", {127'd0, mem_read}, 1);
        tick();
        rst_n = 1'b0;
        tick();
        chk("rstmid_read_drop", {127'd0, mem_read}, 0);
        chk("rstmid_no_ready", {127'd0, d_ready}, 0);
        d_read = 1'b0; rst_n = 1'b1;
        mem_ready = 1'b1; mem_rdata = {4{32'hFFFF_EEEE}};
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        chk("stray_ready_ignored", {126'd0, i_ready, d_ready}, 0);
        chk("stray_no_strobe", {126'd0, mem_read, mem_write}, 0);
        chk("stray_d_rdata", d_rdata, 0);
        tick();
        chk("stray_later", {124'd0, i_ready, d_ready, mem_read, mem_write}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
